alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have parameter RING_SECS, default 60, giving the maximum ring duration in ticks.
REQ-002 The block SHALL have parameter SNOOZE_MINS, default 5, giving the snooze interval in minutes; legal range is 1..59.
REQ-003 The block SHALL have parameter MAX_SNOOZE, default 3, giving the maximum snoozes per alarm event; legal range is 0..3.
REQ-004 Port Clk: input, 1 bit, the only clock; all state updates on its rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port tick: input, 1 bit, one-Clk pulse per second; seconds, minutes and hours are valid in the tick cycle.
REQ-007 Ports seconds, minutes and hours: inputs, 6/6/5 bits, current time from the upstream clock counter.
REQ-008 Port set_valid: input, 1 bit, alarm-time write request.
REQ-009 Port set_ready: output, 1 bit, write accepted this cycle when high.
REQ-010 Ports set_hour and set_min: inputs, 5/6 bits, requested alarm time.
REQ-011 Port set_err: output, 1 bit, one-cycle pulse on a rejected write.
REQ-012 Port alarm_on: input, 1 bit, level-sensitive arm enable.
REQ-013 Port snooze_btn: input, 1 bit, level input; only rising edges act.
REQ-014 Port stop_btn: input, 1 bit, level input; only rising edges act.
REQ-015 Port buzzer: output, 1 bit, registered, high while ringing.
REQ-016 Port alarm_state: output, 2 bits, encoded IDLE=0, RINGING=1, SNOOZED=2, LOCKOUT=3.
REQ-017 Port snooze_cnt: output, 2 bits, number of snoozes used in the current event.

Function
REQ-018 buzzer SHALL equal 1 exactly when alarm_state==RINGING; both SHALL be registered.
REQ-019 Trigger: in IDLE, transition to RINGING SHALL occur when alarm_on, tick, hours==alarm_hour, minutes==alarm_min and seconds==0 all hold; buzzer rises on the next cycle.
REQ-020 On entry to RINGING, the ring counter SHALL be cleared; it SHALL increment on each tick while in RINGING.
REQ-021 In RINGING, the state SHALL go to LOCKOUT when the ring counter reaches RING_SECS.
REQ-022 In RINGING or SNOOZED, a stop_btn edge SHALL move the state to LOCKOUT.
REQ-023 In RINGING, a snooze_btn edge with snooze_cnt<MAX_SNOOZE SHALL move the state to SNOOZED and increment snooze_cnt.
REQ-024 On that snooze, the wake target SHALL be set to current minutes+SNOOZE_MINS modulo 60, with the hour carried modulo 24.
REQ-025 A snooze_btn edge with snooze_cnt==MAX_SNOOZE SHALL be ignored.
REQ-026 In SNOOZED, the state SHALL go to RINGING on a tick where hours/minutes equal the wake target and seconds==0.
REQ-027 In LOCKOUT, the state SHALL go to IDLE in the first cycle where minutes!=alarm_min, preventing a retrigger in the same minute.
REQ-028 snooze_cnt SHALL clear on entry to IDLE.
REQ-029 Priority SHALL be: alarm_on==0 (forces IDLE from any state, next cycle) > stop > snooze > ring timeout.
REQ-030 set_ready SHALL be combinational, high exactly when alarm_state==IDLE.
REQ-031 A transfer SHALL occur on a cycle with set_valid && set_ready.
REQ-032 A transfer with set_hour>23 or set_min>59 SHALL leave the alarm registers unchanged and pulse set_err on the next cycle.
REQ-033 An accepted write SHALL take effect for comparison from the next cycle; a trigger in the same cycle as a write SHALL use the old alarm value.
REQ-034 Button edges SHALL be detected on Clk-synchronous previous-value registers.

Reset
REQ-035 While reset_n==0 the block SHALL hold: alarm_state=IDLE, buzzer=0, snooze_cnt=0, set_err=0, alarm_hour=0, alarm_min=0, ring counter=0 and wake target=0.
REQ-036 Button previous-value registers SHALL reset to 1, so a button held through reset produces no edge.
REQ-037 Reset asserted mid-ring SHALL drop buzzer immediately and asynchronously.

Configuration
REQ-038 With macro ALARM_SNOOZE_EN defined, snooze behaves per REQ-023 to REQ-026.
REQ-039 Without ALARM_SNOOZE_EN, snooze_btn SHALL be ignored, SNOOZED SHALL be unreachable and snooze_cnt SHALL be tied to 0.

Verification
REQ-040 Write 07:30, alarm_on=1, advance time to 07:30:00 with tick -> buzzer=1 on the next cycle; after 60 ticks, LOCKOUT then IDLE at 07:31.
REQ-041 Ringing at 07:30:10, then a snooze edge -> SNOOZED, snooze_cnt=1, re-ring at 07:35:00; with 23:58 and snooze -> re-ring at 00:03:00.
REQ-042 Snooze pressed 4 times with MAX_SNOOZE=3 -> 4th edge ignored, buzzer stays 1, snooze_cnt=3.
REQ-043 Stop and snooze edges in the same cycle -> LOCKOUT, snooze_cnt unchanged; no retrigger at 07:30:59; IDLE at 07:31.
REQ-044 Write set_hour=24, set_min=10 -> set_err pulse, alarm stays 07:30; write during RINGING -> set_ready=0, no change.
REQ-045 reset_n pulsed low while ringing -> buzzer=0 asynchronously; all outputs at reset values; a held snooze_btn after release produces no edge.

Source files
------------

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm compare with ring, snooze and lockout sequencing
// Snooze support is present only when ALARM_SNOOZE_EN is defined; otherwise snooze_btn is ignored.
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  output logic       set_err,
  input  logic       alarm_on,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic [1:0] alarm_state,
  output logic [1:0] snooze_cnt
);

`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif
  localparam int RW = $clog2(RING_SECS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          buzzer_q;
  logic          set_err_q;
  logic [4:0]    alarm_hour, wake_hour, wake_hour_d;
  logic [5:0]    alarm_min, wake_min, wake_min_d;
  logic [6:0]    min_sum;
  logic [RW-1:0] ring_cnt;
  logic [1:0]    snooze_cnt_q;
  logic          snooze_prev, stop_prev;
  logic          snooze_edge, stop_edge;
  logic          alarm_hit, wake_hit, snooze_take, ring_done;
  logic          write_fire, write_bad;

  assign snooze_edge = snooze_btn & ~snooze_prev;
  assign stop_edge   = stop_btn & ~stop_prev;
  assign alarm_hit   = tick && (hours == alarm_hour) && (minutes == alarm_min) && (seconds == 6'd0);
  assign wake_hit    = tick && (hours == wake_hour) && (minutes == wake_min) && (seconds == 6'd0);
  assign snooze_take = SNOOZE_EN && snooze_edge && (snooze_cnt_q < 2'(MAX_SNOOZE));
  assign ring_done   = (ring_cnt >= RW'(RING_SECS));

  assign set_ready  = (state_q == IDLE);
  assign write_fire = set_valid && set_ready;
  assign write_bad  = (set_hour > 5'd23) || (set_min > 6'd59);

  assign alarm_state = state_q;
  assign buzzer      = buzzer_q;
  assign set_err     = set_err_q;
  assign snooze_cnt  = SNOOZE_EN ? snooze_cnt_q : 2'd0;

  // Wake target: current time plus the snooze interval, wrapping through midnight.
  always_comb begin
    min_sum     = {1'b0, minutes} + 7'(SNOOZE_MINS);
    wake_min_d  = min_sum[5:0];
    wake_hour_d = hours;
    if (min_sum >= 7'd60) begin
      wake_min_d  = 6'(min_sum - 7'd60);
      wake_hour_d = (hours >= 5'd23) ? 5'd0 : hours + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!alarm_on) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit) state_d = RINGING;
        end
        RINGING: begin
          if (stop_edge)        state_d = LOCKOUT;
          else if (snooze_take) state_d = SNOOZED;
          else if (ring_done)   state_d = LOCKOUT;
        end
        SNOOZED: begin
          if (stop_edge)     state_d = LOCKOUT;
          else if (wake_hit) state_d = RINGING;
        end
        LOCKOUT: begin
          if (minutes != alarm_min) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buzzer_q <= (state_d == RINGING);
    end
  end

  // Button history resets high so a button held through reset never looks like a press.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      snooze_prev  <= 1'b1;
      stop_prev    <= 1'b1;
      set_err_q    <= 1'b0;
      alarm_hour   <= 5'd0;
      alarm_min    <= 6'd0;
      ring_cnt     <= '0;
      snooze_cnt_q <= 2'd0;
      wake_hour    <= 5'd0;
      wake_min     <= 6'd0;
    end else begin
      snooze_prev <= snooze_btn;
      stop_prev   <= stop_btn;
      set_err_q   <= write_fire && write_bad;
      if (write_fire && !write_bad) begin
        alarm_hour <= set_hour;
        alarm_min  <= set_min;
      end
      if ((state_d == RINGING) && (state_q != RINGING)) begin
        ring_cnt <= '0;
      end else if ((state_q == RINGING) && tick && !ring_done) begin
        ring_cnt <= ring_cnt + 1'b1;
      end
      if ((state_d == IDLE) && (state_q != IDLE)) begin
        snooze_cnt_q <= 2'd0;
      end else if ((state_q == RINGING) && (state_d == SNOOZED)) begin
        snooze_cnt_q <= snooze_cnt_q + 2'd1;
        wake_hour    <= wake_hour_d;
        wake_min     <= wake_min_d;
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - self-checking bench for alarm_controller
// Snooze expectations follow ALARM_SNOOZE_EN, matching the build of the design.
module tb_alarm_controller;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_MINS = 5;
  localparam int MAX_SNOOZE  = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] seconds = 6'd0;
  logic [5:0] minutes = 6'd0;
  logic [4:0] hours = 5'd0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [4:0] set_hour = 5'd0;
  logic [5:0] set_min = 6'd0;
  logic       set_err;
  logic       alarm_on = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer;
  logic [1:0] alarm_state;
  logic [1:0] snooze_cnt;

  alarm_controller #(
    .RING_SECS  (RING_SECS),
    .SNOOZE_MINS(SNOOZE_MINS),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .set_valid  (set_valid),
    .set_ready  (set_ready),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_err    (set_err),
    .alarm_on   (alarm_on),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .buzzer     (buzzer),
    .alarm_state(alarm_state),
    .snooze_cnt (snooze_cnt)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int tsec = 0;

  // Reference model: state as 0..3, wake target as minute of the day.
  int m_state, m_ring, m_cnt, m_wake, m_ah, m_am;
  bit m_err, m_snz_prev, m_stp_prev;

  typedef struct {
    int h;
    int m;
    bit err;
  } wr_vec_t;
  wr_vec_t vecs[8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ring = 0; m_cnt = 0; m_wake = 0; m_ah = 0; m_am = 0;
    m_err = 0; m_snz_prev = 1; m_stp_prev = 1;
  endtask

  task automatic model_step();
    int ns, nring, ncnt, nwake, now_min;
    bit snz_e, stp_e;
    snz_e = snooze_btn && !m_snz_prev;
    stp_e = stop_btn && !m_stp_prev;
    now_min = int'(hours) * 60 + int'(minutes);
    ns = m_state; nring = m_ring; ncnt = m_cnt; nwake = m_wake;
    if (!alarm_on) ns = 0;
    else if (m_state == 0) begin
      if (tick && int'(hours) == m_ah && int'(minutes) == m_am && seconds == 0) ns = 1;
    end else if (m_state == 1) begin
      if (stp_e) ns = 3;
      else if (SNOOZE_EN && snz_e && m_cnt < MAX_SNOOZE) begin
        ns = 2; ncnt = m_cnt + 1; nwake = (now_min + SNOOZE_MINS) % 1440;
      end else if (m_ring >= RING_SECS) ns = 3;
    end else if (m_state == 2) begin
      if (stp_e) ns = 3;
      else if (tick && seconds == 0 && now_min == m_wake) ns = 1;
    end else begin
      if (int'(minutes) != m_am) ns = 0;
    end
    if (ns == 1 && m_state != 1) nring = 0;
    else if (m_state == 1 && tick) nring = m_ring + 1;
    if (ns == 0 && m_state != 0) ncnt = 0;
    m_err = 0;
    if (set_valid && m_state == 0) begin
      if (set_hour > 23 || set_min > 59) m_err = 1;
      else begin m_ah = int'(set_hour); m_am = int'(set_min); end
    end
    m_state = ns; m_ring = nring; m_cnt = ncnt; m_wake = nwake;
    m_snz_prev = snooze_btn; m_stp_prev = stop_btn;
  endtask

  task automatic cyc();
    check("set_ready", int'(set_ready), int'(m_state == 0));
    @(posedge Clk);
    if (!reset_n) model_reset(); else model_step();
    #1;
    check("alarm_state", int'(alarm_state), m_state);
    check("buzzer", int'(buzzer), int'(m_state == 1));
    check("snooze_cnt", int'(snooze_cnt), m_cnt);
    check("set_err", int'(set_err), int'(m_err));
  endtask

  task automatic apply_time();
    hours   = 5'(tsec / 3600);
    minutes = 6'((tsec / 60) % 60);
    seconds = 6'(tsec % 60);
  endtask

  task automatic goto_time(input int h, input int m, input int s);
    tsec = h * 3600 + m * 60 + s;
    apply_time();
  endtask

  task automatic tick_once();
    tsec = (tsec + 1) % 86400;
    apply_time();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic write_alarm(input int h, input int m);
    set_valid = 1'b1; set_hour = 5'(h); set_min = 6'(m);
    cyc();
    set_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge Clk);
    #1;
    cyc(); cyc();
    check("rst_state", int'(alarm_state), 0);
    check("rst_buzzer", int'(buzzer), 0);
    check("rst_snooze_cnt", int'(snooze_cnt), 0);
    check("rst_set_err", int'(set_err), 0);
    check("rst_set_ready", int'(set_ready), 1);
    reset_n = 1'b1;
    cyc();

    // Alarm writes, including out-of-range rejects.
    vecs[0] = '{5, 0, 1'b0};
    vecs[1] = '{23, 59, 1'b0};
    vecs[2] = '{24, 10, 1'b1};
    vecs[3] = '{0, 60, 1'b1};
    vecs[4] = '{31, 63, 1'b1};
    vecs[5] = '{0, 0, 1'b0};
    vecs[6] = '{7, 30, 1'b0};
    vecs[7] = '{24, 10, 1'b1};
    for (int i = 0; i < 8; i++) begin
      write_alarm(vecs[i].h, vecs[i].m);
      check("wr_err", int'(set_err), int'(vecs[i].err));
      cyc();
      check("wr_err_pulse", int'(set_err), 0);
    end

    // Trigger at 07:30:00 and ring timeout into lockout then idle.
    alarm_on = 1'b1;
    goto_time(7, 29, 58);
    tick_once();
    check("pre_trigger", int'(buzzer), 0);
    tick_once();
    check("trigger_buzzer", int'(buzzer), 1);
    check("trigger_state", int'(alarm_state), 1);
    for (int i = 1; i < 60; i++) begin
      tick_once();
      if (i == 5) begin
        set_valid = 1'b1; set_hour = 5'd8; set_min = 6'd0;
        check("ring_set_ready", int'(set_ready), 0);
      end
      cyc();
      set_valid = 1'b0;
      if (i == 5) check("ring_no_err", int'(set_err), 0);
    end
    check("ring_59", int'(alarm_state), 1);
    tick_once();
    check("ring_60", int'(alarm_state), 1);
    cyc();
    check("timeout_lockout", int'(alarm_state), 3);
    check("timeout_buzzer", int'(buzzer), 0);
    cyc();
    check("lockout_idle", int'(alarm_state), 0);

    // Snooze chain including the ignored press beyond MAX_SNOOZE.
    goto_time(7, 29, 59);
    tick_once();
    check("snz_ring", int'(alarm_state), 1);
    for (int i = 0; i < 10; i++) begin tick_once(); cyc(); end
    for (int k = 1; k <= 4; k++) begin
      snooze_btn = 1'b1;
      cyc();
      check("snz_state", int'(alarm_state), (SNOOZE_EN && k <= MAX_SNOOZE) ? 2 : 1);
      check("snz_cnt", int'(snooze_cnt), SNOOZE_EN ? ((k <= MAX_SNOOZE) ? k : MAX_SNOOZE) : 0);
      check("snz_buzzer", int'(buzzer), (SNOOZE_EN && k <= MAX_SNOOZE) ? 0 : 1);
      snooze_btn = 1'b0;
      cyc();
      if (k <= 3) begin
        goto_time(7, 29 + 5 * k, 59);
        cyc();
        check("snz_wait", int'(alarm_state), SNOOZE_EN ? 2 : 1);
        tick_once();
        check("snz_rering", int'(alarm_state), 1);
        check("snz_rering_buzzer", int'(buzzer), 1);
      end
    end
    stop_btn = 1'b1;
    cyc();
    check("stop_lockout", int'(alarm_state), 3);
    stop_btn = 1'b0;
    cyc();
    check("stop_idle", int'(alarm_state), 0);
    check("stop_idle_cnt", int'(snooze_cnt), 0);

    // Snooze across midnight: 23:58 + 5 -> 00:03.
    write_alarm(23, 58);
    goto_time(23, 57, 59);
    tick_once();
    check("mid_ring", int'(alarm_state), 1);
    cyc();
    snooze_btn = 1'b1;
    cyc();
    check("mid_snz", int'(alarm_state), SNOOZE_EN ? 2 : 1);
    snooze_btn = 1'b0;
    cyc();
    goto_time(0, 2, 59);
    cyc();
    check("mid_wait", int'(alarm_state), SNOOZE_EN ? 2 : 1);
    tick_once();
    check("mid_rering", int'(alarm_state), 1);
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    cyc();
    check("mid_idle", int'(alarm_state), 0);

    // Stop and snooze together; no retrigger within the alarm minute.
    write_alarm(7, 30);
    goto_time(7, 29, 59);
    tick_once();
    for (int i = 0; i < 10; i++) begin tick_once(); cyc(); end
    snooze_btn = 1'b1; stop_btn = 1'b1;
    cyc();
    check("both_lockout", int'(alarm_state), 3);
    check("both_cnt", int'(snooze_cnt), 0);
    snooze_btn = 1'b0; stop_btn = 1'b0;
    cyc();
    for (int i = 0; i < 49; i++) begin tick_once(); cyc(); end
    check("both_hold_5959", int'(alarm_state), 3);
    tick_once();
    check("both_idle_0731", int'(alarm_state), 0);

    // Write in the trigger cycle: old value rings, new value used afterwards.
    goto_time(7, 29, 59);
    cyc();
    set_valid = 1'b1; set_hour = 5'd9; set_min = 6'd15;
    tick_once();
    set_valid = 1'b0;
    check("same_cycle_ring", int'(alarm_state), 1);
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    check("same_cycle_stop", int'(alarm_state), 3);
    cyc();
    check("same_cycle_idle", int'(alarm_state), 0);
    goto_time(9, 14, 59);
    cyc();
    tick_once();
    check("new_alarm_ring", int'(alarm_state), 1);

    // Asynchronous reset mid-ring with both buttons held through it.
    #3;
    reset_n = 1'b0; snooze_btn = 1'b1; stop_btn = 1'b1;
    #1;
    check("async_buzzer", int'(buzzer), 0);
    check("async_state", int'(alarm_state), 0);
    model_reset();
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    goto_time(23, 59, 59);
    tick_once();
    check("post_rst_ring", int'(alarm_state), 1);
    cyc();
    check("held_no_edge", int'(alarm_state), 1);
    snooze_btn = 1'b0; stop_btn = 1'b0;
    cyc();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    goto_time(0, 1, 0);
    cyc();

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      alarm_on   = ($urandom_range(0, 39) != 0);
      snooze_btn = ($urandom_range(0, 5) == 0);
      stop_btn   = ($urandom_range(0, 60) == 0);
      set_valid  = ($urandom_range(0, 30) == 0);
      set_hour   = 5'($urandom_range(0, 31));
      set_min    = 6'($urandom_range(0, 63));
      if (r < 3) begin
        tsec = (m_ah * 3600 + m_am * 60 + 86399) % 86400;
        apply_time();
      end else if (r < 6) begin
        tsec = (m_wake * 60 + 86399) % 86400;
        apply_time();
      end
      if ($urandom_range(0, 1) == 1) tick_once();
      else cyc();
    end
    set_valid = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
